// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle ALU
//
// Single-cycle operations (AND, XOR, SLL, ADD, SUB, SRA, OR, unused codes)
// complete at the accept edge. MUL, DIVU and REMU run on an iterative
// shift-add multiplier / restoring divider that retires one bit per cycle.
// Their result is registered on the WIDTH-th edge after accept.
//
// Handshake: a request is accepted at a rising edge when valid_i=1,
// ready_o=1 and kill_i=0. ready_o is high only in IDLE. A valid_i that
// arrives while ready_o=0 is dropped, not queued. valid_o pulses for one
// cycle whenever ALUout_o/zero_o take a new value.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous reset, active low
//   valid_i    : request qualifier
//   ready_o    : request can be accepted this cycle
//   ALUCtrl_i  : operation select
//   data1_i    : operand 1
//   data2_i    : operand 2 / shift amount / divisor
//   kill_i     : abort an operation in progress; blocks accept
//   valid_o    : one-cycle pulse when a new result is loaded
//   ALUout_o   : registered result
//   zero_o     : registered (ALUout_o == 0)
//   state_o    : debug view of the FSM (0 = IDLE, 1 = BUSY)
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             kill_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ALUout_o,
    output logic             zero_o,
    output logic             state_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_REMU = 4'd9;

    typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;
    typedef enum logic [1:0] { K_MUL = 2'd0, K_DIVU = 2'd1, K_REMU = 2'd2 } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc  : product accumulator (MUL) / partial remainder (DIV)
    // opa  : multiplicand, shifted left (MUL) / divisor (DIV)
    // opb  : multiplier, shifted right (MUL) / dividend turning into quotient (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             is_mc;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] mc_res;

    assign ready_o  = (state_q == IDLE);
    assign accept   = valid_i & ready_o & ~kill_i;
    assign valid_o  = valid_q;
    assign ALUout_o = out_q;
    assign zero_o   = zero_q;
    assign state_o  = state_q;

    assign is_mc = (ALUCtrl_i == OP_MUL) || (ALUCtrl_i == OP_DIVU) || (ALUCtrl_i == OP_REMU);

    // Single-cycle result; unused codes fall through to 0.
    always_comb begin
        sc_res = '0;
        case (ALUCtrl_i)
            OP_AND:  sc_res = data1_i & data2_i;
            OP_XOR:  sc_res = data1_i ^ data2_i;
            OP_SLL:  sc_res = data1_i << data2_i[SHW-1:0];
            OP_ADD:  sc_res = data1_i + data2_i;
            OP_SUB:  sc_res = data1_i - data2_i;
            OP_SRA:  sc_res = $signed(data1_i) >>> data2_i[SHW-1:0];
            OP_OR:   sc_res = data1_i | data2_i;
            default: sc_res = '0;
        endcase
    end

    // One multiplier step: add the multiplicand when the current multiplier bit is set.
    assign mul_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;

    // One restoring-divider step: shift in the next dividend bit, subtract if it fits.
    // A zero divisor always "fits", giving an all-ones quotient and leaving the
    // dividend as remainder without any special case.
    assign div_sh  = {acc_q, opb_q[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, opa_q});
    assign div_rem = div_ge ? WIDTH'(div_sh - {1'b0, opa_q}) : div_sh[WIDTH-1:0];
    assign div_quo = {opb_q[WIDTH-2:0], div_ge};

    always_comb begin
        mc_res = '0;
        case (kind_q)
            K_MUL:   mc_res = mul_acc;
            K_DIVU:  mc_res = div_quo;
            K_REMU:  mc_res = div_rem;
            default: mc_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        out_d   = out_q;
        zero_d  = zero_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mc) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        acc_d   = '0;
                        if (ALUCtrl_i == OP_MUL) begin
                            kind_d = K_MUL;
                            opa_d  = data1_i;
                            opb_d  = data2_i;
                        end else begin
                            kind_d = (ALUCtrl_i == OP_DIVU) ? K_DIVU : K_REMU;
                            opa_d  = data2_i;
                            opb_d  = data1_i;
                        end
                    end else begin
                        out_d   = sc_res;
                        zero_d  = (sc_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (kind_q == K_MUL) begin
                        acc_d = mul_acc;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end else begin
                        acc_d = div_rem;
                        opb_d = div_quo;
                    end
                    // The last step is folded into the result load so the answer
                    // appears on the WIDTH-th edge after accept.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = IDLE;
                        out_d   = mc_res;
                        zero_d  = (mc_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            kind_q  <= K_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_XOR  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_REMU = 4'd9;

  logic         clk_i;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         kill_i;
  logic         valid_o;
  logic [W-1:0] alu_out;
  logic         zero_o;
  logic         state_o;

  int total;
  int bad;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (alu_ctrl),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .kill_i    (kill_i),
    .valid_o   (valid_o),
    .ALUout_o  (alu_out),
    .zero_o    (zero_o),
    .state_o   (state_o)
  );

  // clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic v);
    alu_ctrl = op;
    data1_i  = a;
    data2_i  = b;
    valid_i  = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one multi-cycle op, then wait (bounded) for its result pulse.
  task automatic run_mc(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    int n;
    logic early_ready;
    drive(op, a, b, 1'b1);
    tick();
    valid_i     = 1'b0;
    n           = 0;
    early_ready = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      if (valid_o) break;
      if (ready_o) early_ready = 1'b1;
    end
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_valid"}, 64'(valid_o), 64'd1);
    check({tag, "_res"}, 64'(alu_out), 64'(exp));
    check({tag, "_zero"}, 64'(zero_o), 64'(exp == '0));
    check({tag, "_ready_low"}, 64'(early_ready), 64'd0);
  endtask

  initial begin
    logic seen;
    total   = 0;
    bad     = 0;
    rst_i   = 1'b1;
    kill_i  = 1'b0;
    drive(OP_AND, '0, '0, 1'b0);
    #1 rst_i = 1'b0;
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_out", 64'(alu_out), 64'd0);
    check("rst_zero", 64'(zero_o), 64'd1);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_state", 64'(state_o), 64'd0);
    tick();
    tick();
    @(negedge clk_i);
    rst_i = 1'b1;

    // first edge after reset release: ADD overflow wraps
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    tick();
    check("add_valid", 64'(valid_o), 64'd1);
    check("add_res", 64'(alu_out), 64'h8000_0000);
    check("add_zero", 64'(zero_o), 64'd0);
    check("add_ready", 64'(ready_o), 64'd1);

    // back-to-back SUB
    drive(OP_SUB, 32'd5, 32'd5, 1'b1);
    tick();
    check("sub_valid", 64'(valid_o), 64'd1);
    check("sub_res", 64'(alu_out), 64'd0);
    check("sub_zero", 64'(zero_o), 64'd1);

    // idle cycle: no pulse, result held
    valid_i = 1'b0;
    tick();
    check("idle_valid", 64'(valid_o), 64'd0);
    check("idle_hold", 64'(alu_out), 64'd0);

    drive(OP_SRA, 32'h8000_0000, 32'h0000_0024, 1'b1);
    tick();
    check("sra_res", 64'(alu_out), 64'hF800_0000);
    drive(OP_SLL, 32'h0000_0001, 32'h0000_0021, 1'b1);
    tick();
    check("sll_res", 64'(alu_out), 64'h0000_0002);
    drive(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    tick();
    check("and_res", 64'(alu_out), 64'hF000_F000);
    drive(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    tick();
    check("xor_res", 64'(alu_out), 64'h0FF0_0FF0);
    drive(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1);
    tick();
    check("or_res", 64'(alu_out), 64'hFFF0_FFF0);
    drive(4'd12, 32'h1234_5678, 32'h1111_1111, 1'b1);
    tick();
    check("op12_valid", 64'(valid_o), 64'd1);
    check("op12_res", 64'(alu_out), 64'd0);
    check("op12_zero", 64'(zero_o), 64'd1);

    // MUL with an ADD offered while busy
    drive(OP_MUL, 32'hFFFF_FFFF, 32'd3, 1'b1);
    tick();
    check("mul_acc_ready", 64'(ready_o), 64'd0);
    check("mul_acc_valid", 64'(valid_o), 64'd0);
    drive(OP_ADD, 32'd1, 32'd1, 1'b1);
    seen = 1'b0;
    for (int k = 1; k < 32; k++) begin
      tick();
      if (valid_o || ready_o) seen = 1'b1;
    end
    check("mul_busy", 64'(seen), 64'd0);
    tick();
    check("mul_valid", 64'(valid_o), 64'd1);
    check("mul_res", 64'(alu_out), 64'hFFFF_FFFD);
    check("mul_zero", 64'(zero_o), 64'd0);
    check("mul_ready", 64'(ready_o), 64'd1);
    valid_i = 1'b0;
    tick();
    check("mul_after_valid", 64'(valid_o), 64'd0);
    check("mul_after_hold", 64'(alu_out), 64'hFFFF_FFFD);

    run_mc("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_mc("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_mc("divu0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_mc("remu0", OP_REMU, 32'd9, 32'd0, 32'd9);
    run_mc("mul2", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);

    // restore a nonzero held result
    drive(OP_ADD, 32'd4, 32'd5, 1'b1);
    tick();
    check("pre_kill_res", 64'(alu_out), 64'd9);

    // kill at cycle 10 of a MUL
    drive(OP_MUL, 32'd7, 32'd9, 1'b1);
    tick();
    valid_i = 1'b0;
    repeat (9) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    check("kill_valid", 64'(valid_o), 64'd0);
    check("kill_ready", 64'(ready_o), 64'd1);
    check("kill_hold", 64'(alu_out), 64'd9);
    check("kill_zero", 64'(zero_o), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    check("kill_no_pulse", 64'(seen), 64'd0);

    // kill has priority over valid_i in IDLE
    drive(OP_ADD, 32'd1, 32'd1, 1'b1);
    kill_i = 1'b1;
    tick();
    kill_i  = 1'b0;
    valid_i = 1'b0;
    check("kill_pri_valid", 64'(valid_o), 64'd0);
    check("kill_pri_hold", 64'(alu_out), 64'd9);
    check("kill_pri_state", 64'(state_o), 64'd0);

    // reset in the middle of a MUL
    drive(OP_MUL, 32'd5, 32'd5, 1'b1);
    tick();
    valid_i = 1'b0;
    check("rmul_busy", 64'(state_o), 64'd1);
    repeat (5) tick();
    #2 rst_i = 1'b0;
    #1;
    check("rmul_valid", 64'(valid_o), 64'd0);
    check("rmul_out", 64'(alu_out), 64'd0);
    check("rmul_zero", 64'(zero_o), 64'd1);
    check("rmul_ready", 64'(ready_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    check("rmul_no_pulse", 64'(seen), 64'd0);
    check("rmul_hold", 64'(alu_out), 64'd0);

    drive(OP_ADD, 32'd2, 32'd3, 1'b1);
    tick();
    valid_i = 1'b0;
    check("post_rst_valid", 64'(valid_o), 64'd1);
    check("post_rst_res", 64'(alu_out), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
